// File: rtl/hoplite_client.sv
// PE-side Hoplite client: injection FIFO toward the switch PE port, ejection FIFO toward the PE.
// Optional traffic counters are compiled in with `define HOPLITE_CLIENT_STATS_EN.
module hoplite_client #(
  parameter int P_W      = 32,
  parameter int X_AW     = 2,
  parameter int Y_AW     = 2,
  parameter int INJ_LOG2 = 2,
  parameter int EJ_LOG2  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [P_W-1:0] pe_tx_pkt,
  input  logic           pe_tx_vld,
  output logic           pe_tx_rdy,
  output logic [P_W-1:0] sw_in_pkt,
  output logic           sw_in_vld,
  input  logic           sw_in_rdy,
  input  logic [P_W-1:0] sw_ej_pkt,
  input  logic           sw_ej_vld,
  output logic [P_W-1:0] pe_rx_pkt,
  output logic           pe_rx_vld,
  input  logic           pe_rx_rdy,
  output logic           ej_ovf
`ifdef HOPLITE_CLIENT_STATS_EN
  ,
  output logic [31:0]    stat_inj,
  output logic [31:0]    stat_ej,
  output logic [31:0]    stat_stall
`endif
);

  localparam int INJ_DEPTH = 1 << INJ_LOG2;
  localparam int EJ_DEPTH  = 1 << EJ_LOG2;

  // The destination X/Y fields live in the low bits of the packet and must fit.
  if (X_AW + Y_AW > P_W) begin : g_addr_check
    $error("hoplite_client: X_AW + Y_AW exceeds P_W");
  end

  logic [P_W-1:0]    inj_mem [INJ_DEPTH];
  logic [INJ_LOG2:0] inj_wr;
  logic [INJ_LOG2:0] inj_rd;
  logic              inj_empty;
  logic              inj_full;
  logic              inj_push;
  logic              inj_pop;

  logic [P_W-1:0]    ej_mem [EJ_DEPTH];
  logic [EJ_LOG2:0]  ej_wr;
  logic [EJ_LOG2:0]  ej_rd;
  logic              ej_empty;
  logic              ej_full;
  logic              ej_push;
  logic              ej_pop;
  logic              ej_drop;

  always_comb begin
    inj_empty = (inj_wr == inj_rd);
    inj_full  = (inj_wr[INJ_LOG2] != inj_rd[INJ_LOG2]) &&
                (inj_wr[INJ_LOG2-1:0] == inj_rd[INJ_LOG2-1:0]);
    ej_empty  = (ej_wr == ej_rd);
    ej_full   = (ej_wr[EJ_LOG2] != ej_rd[EJ_LOG2]) &&
                (ej_wr[EJ_LOG2-1:0] == ej_rd[EJ_LOG2-1:0]);
  end

  // Handshake outputs come from registered pointers only, so sw_in_rdy never loops back.
  always_comb begin
    pe_tx_rdy = !inj_full;
    sw_in_vld = !inj_empty;
    sw_in_pkt = inj_mem[inj_rd[INJ_LOG2-1:0]];
    pe_rx_vld = !ej_empty;
    pe_rx_pkt = ej_mem[ej_rd[EJ_LOG2-1:0]];
  end

  always_comb begin
    inj_push = pe_tx_vld && !inj_full;
    inj_pop  = !inj_empty && sw_in_rdy;
    ej_pop   = !ej_empty && pe_rx_rdy;
    ej_push  = sw_ej_vld && (!ej_full || ej_pop);
    ej_drop  = sw_ej_vld && ej_full && !ej_pop;
  end

  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wr[INJ_LOG2-1:0]] <= pe_tx_pkt;
    if (ej_push)  ej_mem[ej_wr[EJ_LOG2-1:0]]    <= sw_ej_pkt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_wr <= '0;
      inj_rd <= '0;
      ej_wr  <= '0;
      ej_rd  <= '0;
      ej_ovf <= 1'b0;
    end else begin
      if (inj_push) inj_wr <= inj_wr + 1'b1;
      if (inj_pop)  inj_rd <= inj_rd + 1'b1;
      if (ej_push)  ej_wr  <= ej_wr + 1'b1;
      if (ej_pop)   ej_rd  <= ej_rd + 1'b1;
      if (ej_drop)  ej_ovf <= 1'b1;
    end
  end

`ifdef HOPLITE_CLIENT_STATS_EN
  // A stall is a cycle where the head was offered but the switch did not take it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_inj   <= '0;
      stat_ej    <= '0;
      stat_stall <= '0;
    end else begin
      if (inj_pop)                 stat_inj   <= stat_inj + 32'd1;
      if (ej_push)                 stat_ej    <= stat_ej + 32'd1;
      if (sw_in_vld && !sw_in_rdy) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hoplite_client.sv
// Self-checking bench for hoplite_client: directed scenarios plus random traffic against a queue model.
// Define HOPLITE_CLIENT_STATS_EN to also check the statistics counters.
module tb_hoplite_client;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pe_tx_pkt;
  logic        pe_tx_vld;
  logic        pe_tx_rdy;
  logic [31:0] sw_in_pkt;
  logic        sw_in_vld;
  logic        sw_in_rdy;
  logic [31:0] sw_ej_pkt;
  logic        sw_ej_vld;
  logic [31:0] pe_rx_pkt;
  logic        pe_rx_vld;
  logic        pe_rx_rdy;
  logic        ej_ovf;
`ifdef HOPLITE_CLIENT_STATS_EN
  logic [31:0] stat_inj;
  logic [31:0] stat_ej;
  logic [31:0] stat_stall;
`endif

  hoplite_client dut (
    .clk(clk),
    .rst(rst),
    .pe_tx_pkt(pe_tx_pkt),
    .pe_tx_vld(pe_tx_vld),
    .pe_tx_rdy(pe_tx_rdy),
    .sw_in_pkt(sw_in_pkt),
    .sw_in_vld(sw_in_vld),
    .sw_in_rdy(sw_in_rdy),
    .sw_ej_pkt(sw_ej_pkt),
    .sw_ej_vld(sw_ej_vld),
    .pe_rx_pkt(pe_rx_pkt),
    .pe_rx_vld(pe_rx_vld),
    .pe_rx_rdy(pe_rx_rdy),
    .ej_ovf(ej_ovf)
`ifdef HOPLITE_CLIENT_STATS_EN
    ,
    .stat_inj(stat_inj),
    .stat_ej(stat_ej),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: two bounded queues of depth 4 plus sticky overflow and counters.
  logic [31:0] inj_q[$];
  logic [31:0] ej_q[$];
  logic        m_ovf;
  int unsigned m_inj;
  int unsigned m_ej;
  int unsigned m_stall;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic modelEdge();
    bit inj_ok;
    bit ej_popped;
    if (rst) begin
      inj_q.delete();
      ej_q.delete();
      m_ovf = 1'b0;
      m_inj = 0;
      m_ej = 0;
      m_stall = 0;
    end else begin
      inj_ok = pe_tx_vld && (inj_q.size() < 4);
      if (inj_q.size() > 0 && !sw_in_rdy) m_stall++;
      if (inj_q.size() > 0 && sw_in_rdy) begin
        void'(inj_q.pop_front());
        m_inj++;
      end
      if (inj_ok) inj_q.push_back(pe_tx_pkt);
      ej_popped = (ej_q.size() > 0) && pe_rx_rdy;
      if (ej_popped) void'(ej_q.pop_front());
      if (sw_ej_vld) begin
        if (ej_q.size() < 4) begin
          ej_q.push_back(sw_ej_pkt);
          m_ej++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".pe_tx_rdy"}, {31'd0, pe_tx_rdy}, {31'd0, inj_q.size() < 4});
    chk({tag, ".sw_in_vld"}, {31'd0, sw_in_vld}, {31'd0, inj_q.size() != 0});
    if (inj_q.size() != 0) chk({tag, ".sw_in_pkt"}, sw_in_pkt, inj_q[0]);
    chk({tag, ".pe_rx_vld"}, {31'd0, pe_rx_vld}, {31'd0, ej_q.size() != 0});
    if (ej_q.size() != 0) chk({tag, ".pe_rx_pkt"}, pe_rx_pkt, ej_q[0]);
    chk({tag, ".ej_ovf"}, {31'd0, ej_ovf}, {31'd0, m_ovf});
`ifdef HOPLITE_CLIENT_STATS_EN
    chk({tag, ".stat_inj"}, stat_inj, m_inj);
    chk({tag, ".stat_ej"}, stat_ej, m_ej);
    chk({tag, ".stat_stall"}, stat_stall, m_stall);
`endif
  endtask

  // Drive one cycle of inputs (from the negedge), clock it, then check at the next negedge.
  task automatic applyStimulus(input string tag, input logic r,
                               input logic tv, input logic [31:0] tp, input logic sr,
                               input logic ev, input logic [31:0] ep, input logic rr);
    rst = r;
    pe_tx_vld = tv;
    pe_tx_pkt = tp;
    sw_in_rdy = sr;
    sw_ej_vld = ev;
    sw_ej_pkt = ep;
    pe_rx_rdy = rr;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input logic sr, input logic rr);
    for (int i = 0; i < n; i++) applyStimulus("idle", 1'b0, 1'b0, 32'h0, sr, 1'b0, 32'h0, rr);
  endtask

  initial begin
    @(negedge clk);
    applyStimulus("reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset.tx_rdy_const", {31'd0, pe_tx_rdy}, 32'd1);
    chk("reset.sw_in_vld_const", {31'd0, sw_in_vld}, 32'd0);
    chk("reset.pe_rx_vld_const", {31'd0, pe_rx_vld}, 32'd0);
    chk("reset.ej_ovf_const", {31'd0, ej_ovf}, 32'd0);

    $display("[TB] back-to-back injection");
    applyStimulus("inj1", 1'b0, 1'b1, 32'hA1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("inj1.head_const", sw_in_pkt, 32'hA1);
    applyStimulus("inj2", 1'b0, 1'b1, 32'hA2, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("inj2.head_const", sw_in_pkt, 32'hA2);
    applyStimulus("inj3", 1'b0, 1'b1, 32'hA3, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("inj3.head_const", sw_in_pkt, 32'hA3);
    idle(2, 1'b1, 1'b0);

    $display("[TB] blocked switch, injection fill");
    applyStimulus("blk1", 1'b0, 1'b1, 32'hA1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("blk_hold", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("blk_hold.head_const", sw_in_pkt, 32'hA1);
    end
    applyStimulus("blk2", 1'b0, 1'b1, 32'hA2, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("blk3", 1'b0, 1'b1, 32'hA3, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("blk4", 1'b0, 1'b1, 32'hA4, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("blk4.full_const", {31'd0, pe_tx_rdy}, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus("blk5", 1'b0, 1'b1, 32'hA5, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("rel1", 1'b0, 1'b1, 32'hA5, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("rel1.head_const", sw_in_pkt, 32'hA2);
    for (int i = 0; i < 2; i++) applyStimulus("rel", 1'b0, 1'b1, 32'hA5, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(4, 1'b1, 1'b0);

    $display("[TB] ejection overflow");
    for (int i = 0; i < 4; i++)
      applyStimulus("ej_fill", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hE0 + i, 1'b0);
    applyStimulus("ej_drop", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hEE, 1'b0);
    chk("ej_drop.ovf_const", {31'd0, ej_ovf}, 32'd1);
    chk("ej_drop.head_const", pe_rx_pkt, 32'hE0);
    idle(5, 1'b0, 1'b1);

    $display("[TB] ejection full with simultaneous drain");
    applyStimulus("rst2", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus("ej_fill2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hD0 + i, 1'b0);
    applyStimulus("ej_swap", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hD9, 1'b1);
    chk("ej_swap.ovf_const", {31'd0, ej_ovf}, 32'd0);
    idle(5, 1'b0, 1'b1);

`ifdef HOPLITE_CLIENT_STATS_EN
    $display("[TB] statistics");
    applyStimulus("st_rst", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("st1", 1'b0, 1'b1, 32'h51, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("st2", 1'b0, 1'b1, 32'h52, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("st3", 1'b0, 1'b1, 32'h53, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(3, 1'b1, 1'b0);
    chk("st.inj_const", stat_inj, 32'd3);
    chk("st.stall_const", stat_stall, 32'd2);
    applyStimulus("st4", 1'b0, 1'b1, 32'h54, 1'b0, 1'b1, 32'h61, 1'b0);
    applyStimulus("st_mid_rst", 1'b1, 1'b1, 32'h55, 1'b0, 1'b1, 32'h62, 1'b0);
    chk("st_mid_rst.inj_const", stat_inj, 32'd0);
    chk("st_mid_rst.stall_const", stat_stall, 32'd0);
`endif

    $display("[TB] random traffic");
    applyStimulus("rnd_rst", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      applyStimulus("rnd", ($urandom_range(0, 149) == 0),
                    ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 1) != 0), $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
